// File: rtl/prescaled_counter.sv
// prescaled_counter: single-clock prescaler plus modulo-MODULUS up/down counter.
// A step strobe fires every DIV = CLK_HZ / TICK_HZ enabled cycles and advances q.
// tick marks every stepped value and tc marks a wrapped value. No derived clock
// is produced.
// Optional feature: define PRESCALED_COUNTER_LOAD_EN to enable the synchronous
// load path. Without it, load/load_val are still ports but are ignored.
module prescaled_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    // The prescaler needs at least one bit, even when DIV == 1.
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);
    // One extra bit so that MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MODULUS);

    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             load_s;

    // A load value outside the count range is clamped to the top value.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} >= MOD_W) begin
            r = Q_MAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

`ifdef PRESCALED_COUNTER_LOAD_EN
    assign load_s = load;
`else
    // The load request is tied off here. The port stays, so both builds share
    // one pin list.
    logic unused_load_s;
    assign unused_load_s = load;
    assign load_s        = 1'b0;
`endif

    // Next-state logic: load, then hold, then prescale, then step.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        tc_d      = 1'b0;
        if (load_s) begin
            cnt_d     = clamp_load(load_val);
            pre_cnt_d = '0;
        end else if (!en) begin
            pre_cnt_d = pre_cnt_q;
        end else if (pre_cnt_q != PRE_LAST) begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
        end else begin
            pre_cnt_d = '0;
            tick_d    = 1'b1;
            if (up_dn) begin
                if (cnt_q == Q_MAX) begin
                    cnt_d = Q_ZERO;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + Q_ONE;
                end
            end else begin
                if (cnt_q == Q_ZERO) begin
                    cnt_d = Q_MAX;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - Q_ONE;
                end
            end
        end
    end

    // State register with synchronous reset; the reset discards prescaler progress.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tick = tick_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter.
// It has one DIV=10 instance and one DIV=1 instance, both with MODULUS=10.
// A reference model pushes the expected outputs to a scoreboard queue as the
// stimulus is driven. After the clock edge the entries are popped and compared.
module tb_prescaled_counter;

`ifdef PRESCALED_COUNTER_LOAD_EN
    localparam bit LOAD_ON = 1'b1;
`else
    localparam bit LOAD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] q, q1;
    logic       tick, tc, tick1, tc1;

    always #5 clk = ~clk;

    prescaled_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .MODULUS(10)) dut (
        .clk_in(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tick(tick), .tc(tc));

    prescaled_counter #(.CLK_HZ(10), .TICK_HZ(10), .WIDTH(4), .MODULUS(10)) dut1 (
        .clk_in(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q1), .tick(tick1), .tc(tc1));

    typedef struct {
        int q;
        int tick;
        int tc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   m_pre[2], m_q[2], m_tick[2], m_tc[2];
    int   m_div[2] = '{10, 1};
    int   n_cmp = 0;
    int   n_err = 0;

    // Count one comparison and report it if the values differ.
    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour of one instance for a single clock edge.
    task automatic model_edge(input int k, input bit r, input bit e, input bit u,
                              input bit l, input int lv);
        m_tick[k] = 0;
        m_tc[k]   = 0;
        if (r) begin
            m_pre[k] = 0;
            m_q[k]   = 0;
        end else if (LOAD_ON && l) begin
            m_q[k]   = (lv >= 10) ? 9 : lv;
            m_pre[k] = 0;
        end else if (e) begin
            if (m_pre[k] < m_div[k] - 1) begin
                m_pre[k]++;
            end else begin
                m_pre[k]  = 0;
                m_tick[k] = 1;
                if (u) begin
                    if (m_q[k] == 9) begin m_q[k] = 0; m_tc[k] = 1; end
                    else m_q[k]++;
                end else begin
                    if (m_q[k] == 0) begin m_q[k] = 9; m_tc[k] = 1; end
                    else m_q[k]--;
                end
            end
        end
    endtask

    // Drive one cycle, push the predictions, then pop them and compare after the edge.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x0, x1;
        rst = r; en = e; up_dn = u; load = l; load_val = 4'(lv);
        model_edge(0, r, e, u, l, lv);
        model_edge(1, r, e, u, l, lv);
        sb0.push_back('{m_q[0], m_tick[0], m_tc[0]});
        sb1.push_back('{m_q[1], m_tick[1], m_tc[1]});
        @(posedge clk);
        #1;
        x0 = sb0.pop_front();
        x1 = sb1.pop_front();
        check("q",     int'(q),     x0.q);
        check("tick",  int'(tick),  x0.tick);
        check("tc",    int'(tc),    x0.tc);
        check("q1",    int'(q1),    x1.q);
        check("tick1", int'(tick1), x1.tick);
        check("tc1",   int'(tc1),   x1.tc);
    endtask

    function automatic int rnd4();
        return int'($urandom_range(15, 0));
    endfunction

    // Directed scenarios; every cycle is also checked against the model.
    initial begin
        int n_tick, n_tc, tc_at, n_tc1, first, q_at;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;

        // Reset state, then a 100-cycle up count.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 6);
        check("rst_q", int'(q), 0);
        check("rst_tick", int'(tick), 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
        n_tick = 0; n_tc = 0; tc_at = 0; n_tc1 = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, rnd4());
            if (tick) n_tick++;
            if (tc) begin n_tc++; tc_at = i; end
            if (tc1) n_tc1++;
            if (i == 10) check("up_first_q", int'(q), 1);
        end
        check("up_ticks", n_tick, 10);
        check("up_tc_cnt", n_tc, 1);
        check("up_tc_at", tc_at, 100);
        check("up_q_end", int'(q), 0);
        check("div1_tc_cnt", n_tc1, 10);

        // Down count from reset.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("dn_q1", int'(q), 9);
        check("dn_tc1", int'(tc), 1);
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("dn_q2", int'(q), 8);
        check("dn_tc2", int'(tc), 0);

        // Pause: 4 enabled cycles, 7 paused cycles, then run until the first tick.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 5; i <= 11; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
            check("pause_q", int'(q), 0);
        end
        first = 0;
        for (int i = 12; i <= 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
            if (tick && first == 0) first = i;
        end
        check("pause_first_tick", first, 17);

        // Load on cycle 5 while enabled, then the following step.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 6);
        check("load_q", int'(q), LOAD_ON ? 6 : 0);
        check("load_tick", int'(tick), 0);
        first = 0; q_at = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 6);
            if (tick && first == 0) begin first = i; q_at = int'(q); end
        end
        check("load_next_tick", first, LOAD_ON ? 10 : 5);
        check("load_next_q", q_at, LOAD_ON ? 7 : 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 13);
        check("load_clamp", int'(q), LOAD_ON ? 9 : 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 6);
        check("load_rst", int'(q), 0);

        // Random traffic, checked against the model on every cycle.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(40, 0) == 0), ($urandom_range(3, 0) != 0),
                  ($urandom_range(1, 0) == 1), ($urandom_range(15, 0) == 0), rnd4());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

Parametrised successor to the fixed 50 MHz→1 Hz divider plus 4-bit up counter pair. A single-clock block: an internal prescaler generates a step strobe every `DIV = CLK_HZ / TICK_HZ` enabled cycles, and a `WIDTH`-bit modulo-`MODULUS` counter advances on each strobe. No derived clock is produced. Adds up/down direction, terminal-count and tick pulses, and an optional synchronous load. It replaces divider-plus-counter pairs anywhere in the design that need slow counters.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency in Hz.
- `TICK_HZ`, 1: step rate in Hz. `DIV = CLK_HZ / TICK_HZ` (integer division) must be ≥ 1.
- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 16: count range `0..MODULUS-1`. Requires `2 ≤ MODULUS ≤ 2**WIDTH`.
- `clk_in`  input  1  system clock. Every flop is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  enable. When low, the prescaler and counter both freeze.
- `up_dn`  input  1  direction: 1 = count up, 0 = count down.
- `load`  input  1  synchronous load request. Used only with `PRESCALED_COUNTER_LOAD_EN`.
- `load_val`  input  WIDTH  value to load.
- `q`  output  WIDTH  counter value (registered).
- `tick`  output  1  one-cycle pulse in the cycle where `q` shows a new stepped value.
- `tc`  output  1  one-cycle pulse in the cycle where `q` shows a value reached by wrapping.

## Operation
- The prescaler `pre_cnt` has width `$clog2(DIV)`, minimum 1 bit.
- Step condition: `step = en && (pre_cnt == DIV-1)`.
- Per edge, in priority order:
  1. `rst`: `q=0`, `pre_cnt=0`, `tick=0`, `tc=0`.
  2. `load` (macro defined only):
     - `q = load_val`, clamped to `MODULUS-1` when `load_val ≥ MODULUS`.
     - `pre_cnt = 0`, `tick=0`, `tc=0`.
     - `en` is ignored for this edge.
  3. `en=0`: `pre_cnt` and `q` hold; `tick=0`, `tc=0`.
  4. `en=1`, not a step: `pre_cnt++`; `tick=0`, `tc=0`.
  5. `step`: `pre_cnt=0`, `tick=1`, and:
     - Up: `q==MODULUS-1` → `q=0`, `tc=1`; otherwise `q++`, `tc=0`.
     - Down: `q==0` → `q=MODULUS-1`, `tc=1`; otherwise `q--`, `tc=0`.
- `up_dn` is sampled only on step edges, so a direction change mid-period applies to the next step.
- When `DIV==1`, every enabled cycle is a step.
- Arithmetic is modulo `MODULUS` and never wraps at `2**WIDTH` unless `MODULUS==2**WIDTH`.

## Timing
- Reset:
  - Outputs read `q=0`, `tick=0`, `tc=0` from the first edge with `rst=1`.
  - The first step occurs `DIV` enabled cycles after reset is released.
- Period: with `en` held high, `tick` pulses exactly every `DIV` cycles.
  - Defaults (50 MHz / 1 Hz): once per 50,000,000 cycles.
- Latency:
  - `q`, `tick` and `tc` change on the same edge as the step; all are registered with no combinational path from inputs.
  - Load takes effect on the edge where `load=1`.
- Pause: dropping `en` for N cycles delays the next step by exactly N cycles, because prescaler progress is retained.
- Reset mid-period discards partial prescaler progress.

## Configuration
- Macro: `PRESCALED_COUNTER_LOAD_EN`.
- Defined: the load path operates as in Operation rule 2.
- Undefined: `load` and `load_val` remain ports but are ignored internally; the port list is identical in both builds.

## Test plan
All scenarios use `CLK_HZ=10`, `TICK_HZ=1` (`DIV=10`), `WIDTH=4`, `MODULUS=10`, with the macro defined unless stated.
- Reset then `en=1`, `up_dn=1` for 100 cycles:
  - `tick` pulses at cycles 10, 20, …, 100.
  - `q` steps 1..9 then 0.
  - `tc=1` only at cycle 100 (9→0).
- Down count from reset, `en=1`, `up_dn=0`:
  - First step gives `q=9` with `tc=1`.
  - Next step gives `q=8` with `tc=0`.
- `en` dropped for 7 cycles after 4 enabled cycles: first `tick` arrives at cycle 17, not 10; `q` holds throughout the pause.
- Load:
  - `load=1`, `load_val=6` on cycle 5 → `q=6`, no `tick`; next `tick` 10 cycles later gives `q=7`.
  - `load_val=13` → `q=9`.
  - `load=1` with `rst=1` → `q=0`.
- Macro undefined: `load=1`, `load_val=6` has no effect; `q` and the tick timing match the plain up-count scenario.
- `DIV=1` (`TICK_HZ=10`), up: `q` increments every cycle; `tc` pulses every 10th cycle.
